// File: rtl/aui_pkg.sv
// Shared constants, FSM state type and AM symbol lookup for the AUI lane framer.
package aui_pkg;

    localparam int AM_BEATS = 4;
    localparam int AM_K_W   = $clog2(AM_BEATS);
    localparam int AM_SYM_W = 10;

    localparam logic [AM_SYM_W-1:0] AM_BASE [AM_BEATS] = '{10'h2C1, 10'h168, 10'h21F, 10'h0E6};

    typedef enum logic [0:0] {ST_AM, ST_DATA} state_e;

    // Lane index is folded into the base pattern so every lane's marker is unique.
    function automatic logic [AM_SYM_W-1:0] am_symbol(input int lane, input logic [AM_K_W-1:0] k);
        return AM_BASE[k] ^ AM_SYM_W'(lane);
    endfunction

endpackage

// File: rtl/aui_am_inserter_if.sv
// Symbol-beat bus between the FEC distributor (master) and the lane framer (slave).
interface aui_am_inserter_if #(
    parameter int NUMBER_LANES   = 16,
    parameter int SYMBOL_WIDTH   = 10,
    parameter int AM_COUNT_WIDTH = 16
);
    logic [NUMBER_LANES*SYMBOL_WIDTH-1:0] i_data;
    logic                                 i_valid;
    logic                                 o_ready;
    logic [NUMBER_LANES-1:0]              i_lane_enable;
    logic [NUMBER_LANES*SYMBOL_WIDTH-1:0] o_lanes;
    logic                                 o_valid;
    logic                                 o_am;
    logic [NUMBER_LANES-1:0]              o_sync_lane;
    logic [AM_COUNT_WIDTH-1:0]            o_am_count;

    modport slave (
        input  i_data, i_valid, i_lane_enable,
        output o_ready, o_lanes, o_valid, o_am, o_sync_lane, o_am_count
    );

    modport master (
        output i_data, i_valid, i_lane_enable,
        input  o_ready, o_lanes, o_valid, o_am, o_sync_lane, o_am_count
    );
endinterface

// File: rtl/aui_am_rom.sv
// Combinational alignment-marker symbol for one lane at AM beat k.
module aui_am_rom
    import aui_pkg::*;
#(
    parameter int LANE         = 0,
    parameter int SYMBOL_WIDTH = 10
) (
    input  logic [AM_K_W-1:0]       k,
    output logic [SYMBOL_WIDTH-1:0] sym
);
    assign sym = SYMBOL_WIDTH'(am_symbol(LANE, k));
endmodule

// File: rtl/aui_am_inserter.sv
// Transmit lane framer: forwards FEC symbol beats onto the lanes and inserts a
// lane-specific alignment-marker group every AM_PERIOD accepted data beats.
module aui_am_inserter
    import aui_pkg::*;
#(
    parameter int NUMBER_LANES   = 16,
    parameter int SYMBOL_WIDTH   = 10,
    parameter int AM_PERIOD      = 1024,
    parameter int AM_COUNT_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    aui_am_inserter_if.slave bus
);
    localparam int CNT_W = $clog2(AM_PERIOD + 1);

    state_e                                   st_q, st_d;
    logic [AM_K_W-1:0]                        k_q, k_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic [NUMBER_LANES-1:0]                  mask_q, mask_d, eff_mask;
    logic [AM_COUNT_WIDTH-1:0]                am_count_q, am_count_d;
    logic [NUMBER_LANES-1:0][SYMBOL_WIDTH-1:0] lanes_q, lanes_d, data_v, am_sym;
    logic                                     valid_q, valid_d;
    logic                                     am_q, am_d;
    logic [NUMBER_LANES-1:0]                  sync_q, sync_d;

    assign data_v = bus.i_data;

    always_comb begin
        st_d       = st_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        am_count_d = am_count_q;
        valid_d    = 1'b0;
        am_d       = 1'b0;
        sync_d     = '0;
        eff_mask   = mask_q;
        if (st_q == ST_AM) begin
            valid_d = 1'b1;
            am_d    = 1'b1;
            // New enable takes effect on the very beat that samples it.
            if (k_q == '0) begin
                eff_mask = bus.i_lane_enable;
                mask_d   = bus.i_lane_enable;
                sync_d   = bus.i_lane_enable;
            end
            if (k_q == AM_K_W'(AM_BEATS - 1)) begin
                st_d       = ST_DATA;
                k_d        = '0;
                cnt_d      = '0;
                am_count_d = am_count_q + AM_COUNT_WIDTH'(1);
            end else begin
                k_d = k_q + AM_K_W'(1);
            end
        end else if (bus.i_valid) begin
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(AM_PERIOD)) begin
                st_d = ST_AM;
                k_d  = '0;
            end
        end
    end

    for (genvar l = 0; l < NUMBER_LANES; l++) begin : g_lane
        aui_am_rom #(.LANE(l), .SYMBOL_WIDTH(SYMBOL_WIDTH)) u_rom (.k(k_q), .sym(am_sym[l]));
        assign lanes_d[l] = (valid_d && eff_mask[l]) ? ((st_q == ST_AM) ? am_sym[l] : data_v[l]) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= ST_AM;
            k_q        <= '0;
            cnt_q      <= '0;
            mask_q     <= '1;
            am_count_q <= '0;
            lanes_q    <= '0;
            valid_q    <= 1'b0;
            am_q       <= 1'b0;
            sync_q     <= '0;
        end else begin
            st_q       <= st_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            am_count_q <= am_count_d;
            lanes_q    <= lanes_d;
            valid_q    <= valid_d;
            am_q       <= am_d;
            sync_q     <= sync_d;
        end
    end

    assign bus.o_ready     = (st_q == ST_DATA);
    assign bus.o_lanes     = lanes_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_am        = am_q;
    assign bus.o_sync_lane = sync_q;
    assign bus.o_am_count  = am_count_q;

endmodule

// File: tb/tb_aui_am_inserter.sv
// Directed bench for the AUI AM inserter: two instances, AM_PERIOD=8 and a
// small-counter AM_PERIOD=1 build for the wrap check.
module tb_aui_am_inserter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    aui_am_inserter_if #(.NUMBER_LANES(16), .SYMBOL_WIDTH(10), .AM_COUNT_WIDTH(16)) bus_a ();
    aui_am_inserter_if #(.NUMBER_LANES(16), .SYMBOL_WIDTH(10), .AM_COUNT_WIDTH(3))  bus_b ();

    aui_am_inserter #(.NUMBER_LANES(16), .SYMBOL_WIDTH(10), .AM_PERIOD(8), .AM_COUNT_WIDTH(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    aui_am_inserter #(.NUMBER_LANES(16), .SYMBOL_WIDTH(10), .AM_PERIOD(1), .AM_COUNT_WIDTH(3))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] exp_am(input int k, input logic [15:0] m);
        logic [9:0]   base [4] = '{10'h2C1, 10'h168, 10'h21F, 10'h0E6};
        logic [159:0] v = '0;
        for (int l = 0; l < 16; l++)
            if (m[l]) v[l*10 +: 10] = base[k] ^ 10'(l);
        return v;
    endfunction

    function automatic logic [159:0] pat(input int i);
        logic [159:0] v;
        for (int l = 0; l < 16; l++) v[l*10 +: 10] = 10'(i * 16 + l) ^ 10'h2A5;
        return v;
    endfunction

    function automatic logic [159:0] msk(input logic [159:0] v, input logic [15:0] m);
        logic [159:0] r = v;
        for (int l = 0; l < 16; l++) if (!m[l]) r[l*10 +: 10] = '0;
        return r;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_lanes"}, bus_a.o_lanes, 160'(0));
        chk({tag, "_valid"}, 160'(bus_a.o_valid), 160'(0));
        chk({tag, "_am"},    160'(bus_a.o_am), 160'(0));
        chk({tag, "_sync"},  160'(bus_a.o_sync_lane), 160'(0));
        chk({tag, "_ready"}, 160'(bus_a.o_ready), 160'(0));
        chk({tag, "_amcnt"}, 160'(bus_a.o_am_count), 160'(0));
    endtask

    // One AM group on instance A; checked on the negedges showing beats 0..3.
    task automatic chk_am_group(input string tag, input logic [15:0] m, input int amc_after);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({tag, "_am"},    160'(bus_a.o_am), 160'(1));
            chk({tag, "_valid"}, 160'(bus_a.o_valid), 160'(1));
            chk({tag, "_lanes"}, bus_a.o_lanes, exp_am(k, m));
            chk({tag, "_sync"},  160'(bus_a.o_sync_lane), 160'((k == 0) ? m : 16'h0));
            chk({tag, "_ready"}, 160'(bus_a.o_ready), 160'(k == 3));
            chk({tag, "_amcnt"}, 160'(bus_a.o_am_count), 160'((k == 3) ? amc_after : amc_after - 1));
        end
    endtask

    initial begin
        logic [9:0] lane3_exp [4] = '{10'h2C2, 10'h16B, 10'h21C, 10'h0E5};
        logic [9:0] lane3;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        bus_a.i_valid = 1'b0;  bus_a.i_data = '0;  bus_a.i_lane_enable = 16'hFFFF;
        bus_b.i_valid = 1'b1;  bus_b.i_data = pat(0); bus_b.i_lane_enable = 16'hFFFF;

        repeat (2) @(negedge clk);
        chk_zero("rst");
        chk("rst_b_amcnt", 160'(bus_b.o_am_count), 160'(0));

        // Reset release: first AM group, lane 3 hand-checked
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lane3 = bus_a.o_lanes[39:30];
            chk("am0_lane3", 160'(lane3), 160'(lane3_exp[k]));
            chk("am0_lanes", bus_a.o_lanes, exp_am(k, 16'hFFFF));
            chk("am0_sync",  160'(bus_a.o_sync_lane), 160'((k == 0) ? 16'hFFFF : 16'h0));
            chk("am0_ready", 160'(bus_a.o_ready), 160'(k == 3));
            chk("am0_amcnt", 160'(bus_a.o_am_count), 160'(k == 3));
        end

        // i_valid held high: 8 data beats then an AM group
        bus_a.i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_a.i_data = pat(i);
            @(negedge clk);
            chk("full_valid", 160'(bus_a.o_valid), 160'(1));
            chk("full_am",    160'(bus_a.o_am), 160'(0));
            chk("full_lanes", bus_a.o_lanes, pat(i));
            chk("full_ready", 160'(bus_a.o_ready), 160'(i < 7));
        end
        bus_a.i_data = pat(99);
        chk_am_group("full_grp", 16'hFFFF, 2);

        // i_valid toggling 0101..: 16 DATA cycles, idle beats are silent
        for (int c = 0; c < 16; c++) begin
            bus_a.i_valid = (c % 2 == 1);
            bus_a.i_data  = pat(c + 16);
            @(negedge clk);
            chk("tog_valid", 160'(bus_a.o_valid), 160'(c % 2 == 1));
            chk("tog_lanes", bus_a.o_lanes, (c % 2 == 1) ? pat(c + 16) : 160'(0));
            chk("tog_ready", 160'(bus_a.o_ready), 160'(c < 15));
        end
        bus_a.i_valid = 1'b0;
        chk_am_group("tog_grp", 16'hFFFF, 3);

        // Enable change mid-period is deferred to the next AM beat 0
        bus_a.i_lane_enable = 16'h00FF;
        bus_a.i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_a.i_data = pat(i + 40);
            @(negedge clk);
            chk("en_pre_lanes", bus_a.o_lanes, pat(i + 40));
        end
        chk_am_group("en_grp", 16'h00FF, 4);
        for (int i = 0; i < 8; i++) begin
            bus_a.i_data = pat(i + 60);
            @(negedge clk);
            chk("en_post_lanes", bus_a.o_lanes, msk(pat(i + 60), 16'h00FF));
        end

        // Reset during the group, after beat 2 is on the lanes
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_lanes", bus_a.o_lanes, exp_am(k, 16'h00FF));
        end
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        bus_a.i_lane_enable = 16'hFFFF;
        rst = 1'b1;
        chk_am_group("post_rst", 16'hFFFF, 1);

        // AM_PERIOD=1, 3-bit group counter: 1..7, 0, 1 with a 5-cycle cadence
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            int e;
            @(negedge clk);
            e = (cyc >= 4) ? (((cyc - 4) / 5 + 1) % 8) : 0;
            chk("wrap_amcnt", 160'(bus_b.o_am_count), 160'(e));
            chk("wrap_am",    160'(bus_b.o_am), 160'(((cyc - 1) % 5) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aui_am_inserter.md
# aui_am_inserter

Transmit-side lane framer for the 16-lane AUI path. It accepts parallel FEC symbol beats, one symbol per lane per beat, and forwards them onto the lanes. Every `AM_PERIOD` accepted data beats it inserts a lane-specific alignment-marker (AM) group and pulses the per-lane sync flags. It sits between the FEC symbol distributor and the lane outputs, and is the transmit counterpart of the receive-side lane sync/deskew logic in `aui_checker`.

## Interface
Parameters:
- `NUMBER_LANES`, 16: number of physical lanes.
- `SYMBOL_WIDTH`, 10: bits per lane per beat (one RS symbol).
- `AM_PERIOD`, 1024: accepted data beats between AM groups; must be ≥ 1.
- `AM_BEATS`, 4: beats per AM group; fixed by the package constant.
- `AM_COUNT_WIDTH`, 16: width of the AM group counter.

Ports:
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: synchronous, active-low reset.
- `i_data`, in, NUMBER_LANES*SYMBOL_WIDTH: lane L symbol in bits `[L*SYMBOL_WIDTH +: SYMBOL_WIDTH]`.
- `i_valid`, in, 1: `i_data` valid.
- `o_ready`, out, 1: block can accept `i_data` this cycle.
- `i_lane_enable`, in, NUMBER_LANES: per-lane enable; disabled lanes transmit zero.
- `o_lanes`, out, NUMBER_LANES*SYMBOL_WIDTH: lane symbols, packed like `i_data`.
- `o_valid`, out, 1: `o_lanes` carries a data or AM beat.
- `o_am`, out, 1: current output beat is an AM beat.
- `o_sync_lane`, out, NUMBER_LANES: one-cycle pulse on AM beat 0, for enabled lanes only.
- `o_am_count`, out, AM_COUNT_WIDTH: number of AM groups fully emitted; wraps modulo 2^AM_COUNT_WIDTH.

## Operation
- FSM states and transitions:
  - `AM`: beat index k runs 0..AM_BEATS-1; `o_ready`=0. After k=AM_BEATS-1, go to `DATA`, clear the data counter, and increment `o_am_count`.
  - `DATA`: `o_ready`=1. Each handshake (`i_valid`&&`o_ready`) increments the data counter. When the counter reaches AM_PERIOD, go to `AM` with k=0.
- Leaving reset, the FSM enters `AM` with k=0, so markers are sent before any data.
- AM symbol for lane L, beat k: `AM_BASE[k] ^ L`, with L zero-extended to SYMBOL_WIDTH.
- `AM_BASE` = {10'h2C1, 10'h168, 10'h21F, 10'h0E6}.
- AM beats are emitted unconditionally: `o_valid`=1 and `o_am`=1, independent of `i_valid`.
- In `DATA` with no handshake: `o_valid`=0, `o_lanes`=0, counter holds.
- `i_lane_enable` is sampled into an internal mask only on AM beat 0. The mask applies from that beat through the end of the following DATA period.
  - Masked lanes output 0 on both data and AM beats.
  - Masked lanes get no `o_sync_lane` pulse.
  - The reset value of the mask is all-ones.
- `o_sync_lane[L]` is 1 only on AM beat 0, and only if mask[L] is set.
- Counter arithmetic:
  - The data counter is clog2(AM_PERIOD+1) bits and never exceeds AM_PERIOD.
  - `o_am_count` wraps from all-ones to 0 with no flag.

## Timing
- `o_ready` is decoded from the registered state only; there is no combinational path from `i_valid`.
- Latency is 1: data accepted at edge N appears on `o_lanes` with `o_valid`=1 after edge N.
- The AM group starts on the cycle after the AM_PERIOD-th handshake. `o_ready` falls in that same cycle and stays 0 for exactly AM_BEATS cycles.
- A handshake on the last data beat and the transition to `AM` happen on the same edge; no data beat is dropped or duplicated.
- While `rst`=0 at an edge, the next cycle has:
  - `o_lanes`=0, `o_valid`=0, `o_am`=0, `o_sync_lane`=0, `o_ready`=0, `o_am_count`=0;
  - mask all-ones, state `AM` with k=0.
- The first AM beat appears in the cycle after the first edge with `rst`=1.
- Reset asserted mid-group or mid-period aborts the group or period; no partial AM completion.

## Structure
- Package `aui_pkg` holds:
  - `AM_BEATS`;
  - `AM_BASE` constant array;
  - FSM state enum {`ST_AM`, `ST_DATA`};
  - function `am_symbol(lane, k)`.
- One natural sub-module: `aui_am_rom`, a combinational AM symbol generator instantiated per lane via generate. Everything else stays in a single module.

## Test plan
- Reset release, all lanes enabled → 4 AM beats.
  - Lane 3 symbols are 2C2, 16B, 21C, 0E5.
  - `o_sync_lane`=16'hFFFF on beat 0 only.
  - `o_am_count` goes 0→1 after beat 3.
- AM_PERIOD=8, `i_valid` held 1 → exactly 8 data beats, then 4 AM beats. `o_ready` pattern is 0000 11111111 0000; data appears one cycle after acceptance.
- AM_PERIOD=8, `i_valid` toggling 1010… → 16 cycles in `DATA` before AM. `o_valid`=0 on idle cycles and the counter holds.
- `i_lane_enable` changed to 16'h00FF mid-DATA → no effect until the next AM beat 0.
  - From then, lanes 8–15 output 0.
  - `o_sync_lane`=16'h00FF.
- `rst` pulsed low during AM beat 2 → all outputs 0 the next cycle, then a fresh AM group from beat 0; `o_am_count`=0.
- AM_COUNT_WIDTH=3, AM_PERIOD=1 → `o_am_count` sequence 1..7, 0, 1 with no glitch or stall.
